mult3_arbiter: RTL and testbench
================================

Name: mult3_arbiter

Overview:
- Shares one fixed-point 3-input multiplier datapath (a*b*c, Q(WIDTH-FRAC).FRAC) among NREQ requesters, e.g. the delta/gradient units of the backprop engine.
- Round-robin grant, 2-stage pipeline (operand register, result register) with valid/ready backpressure on the result side.
- Each result is tagged with the requester index so results can be routed back.

Parameters:
- WIDTH, 32, operand/result width (signed two's complement)
- FRAC, 24, fractional bits of operands and result
- NREQ, 4, number of requesters (2..16)
- IDW, 2, width of requester index; must equal clog2(NREQ)

Ports:
- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous active-high reset
- i_req  in  NREQ  request per requester; level, held until acked
- i_a  in  NREQ*WIDTH  operand a per requester, slice i = [i*WIDTH +: WIDTH]
- i_b  in  NREQ*WIDTH  operand b, same packing
- i_c  in  NREQ*WIDTH  operand c, same packing
- o_ack  out  NREQ  one-hot (or zero) pulse: operands of requester i captured this cycle
- o_valid  out  1  result valid
- o_ready  in  1  consumer accepts result when o_valid & o_ready
- o_id  out  IDW  index of requester that owns o_result
- o_result  out  WIDTH  signed product
- o_busy  out  1  high while any stage holds an operation

Behaviour:
- Reset: o_ack=0, o_valid=0, o_id=0, o_result=0, o_busy=0, stage-1 valid=0, round-robin pointer=0 (requester 0 highest priority). Reset mid-operation discards all in-flight work; no ack or result for it.
- Pipeline advance: adv = !o_valid | o_ready. Stage 1 (s1_v, s1_a/b/c, s1_id) and stage 2 (o_valid, o_result, o_id) move only when adv=1; when adv=0 both stages hold their values stably.
- Grant: when adv=1 and any i_req set, grant the first requester with i_req=1 searching from pointer upward modulo NREQ; o_ack[g]=1 in that same cycle (combinational from registered pointer and i_req); operands of g registered into stage 1 at the clock edge. When adv=0, o_ack=0.
- Pointer update: on a grant to g, pointer <= (g+1) mod NREQ; no grant, pointer holds.
- Requester protocol: a requester seeing o_ack[i]=1 may change operands or drop i_req next cycle; holding i_req issues another operation, taken again only after others had a turn (fairness: at most NREQ-1 grants between two grants to the same continuously-requesting requester).
- Stage 1 to 2: on adv, o_valid <= s1_v; if s1_v, o_result <= product slice, o_id <= s1_id. s1_v <= grant.
- Latency: ack in cycle N, result valid from cycle N+2 with no backpressure; throughput 1 op/cycle.
- Arithmetic: full signed product P = a*b*c at 3*WIDTH bits; o_result = P[2*FRAC+WIDTH-1 : 2*FRAC]. Truncation toward minus infinity, no rounding, no saturation; overflow wraps (bits above discarded).
- o_busy = s1_v | o_valid.
- Simultaneous o_valid&o_ready and new grant: result leaves, stage 1 moves up, new op enters stage 1 in the same edge — no bubble.
- i_req changes while not acked: no effect on state; arbitration re-evaluated every cycle.

Decomposition:
- Shared package: fixed-point constants (WIDTH, FRAC, ONE = 1<<FRAC) and the requester-index width helper used by other shared-resource arbiters.
- Sub-module: rr_arbiter (NREQ-way round-robin, inputs req/pointer/enable, outputs one-hot grant and encoded index), reusable for other shared datapaths. Product computed by the existing 3-input multiplier module instantiated on stage-1 registers.

Test Plan:
- Single op: req[2]=1, a=0x02000000 (2.0), b=0x00800000 (0.5), c=0x03000000 (3.0), o_ready=1 -> o_ack=0100 in cycle 0, cycle 2 o_valid=1, o_id=2, o_result=0x03000000.
- Sign/truncation: a=0xFF000000 (-1.0), b=0x02000000, c=0x01800000 -> o_result=0xFD000000 (-3.0); a=b=c=0x00000001 -> o_result=0x00000000.
- Round-robin: all four req held 8 cycles, o_ready=1 -> ack order 0,1,2,3,0,1,2,3; o_id sequence same, 2 cycles later.
- Backpressure: o_ready=0 for 5 cycles with all req set -> exactly 2 acks then o_ack=0, o_valid, o_result, o_id stable; o_ready=1 -> results drain in order with no loss or duplication.
- Reset mid-flight: rst asserted 1 cycle while s1_v and o_valid high -> next cycle o_valid=0, o_busy=0, o_result=0, pointer=0 (req[0] and req[3] both set -> ack to 0).
- Overflow wrap: a=b=c=0x10000000 (16.0) -> o_result=0x00000000 (4096.0 wraps), no error flag.

Source files
------------

// File: rtl/mult3_arbiter_pkg.sv
// Shared constants for fixed-point arbitrated datapaths.
package mult3_arbiter_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int FRAC_DEF  = 24;

  // Fixed-point 1.0 in the default Q8.24 format.
  localparam logic [WIDTH_DEF-1:0] ONE = WIDTH_DEF'(1) << FRAC_DEF;

  // Width of a requester index for an n-way arbiter (at least one bit).
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult3_arbiter_mult3.sv
// Signed fixed-point 3-input multiplier: full 3*WIDTH product, keep the
// WIDTH bits starting at 2*FRAC (truncation toward -inf, wrap on overflow).
module mult3_arbiter_mult3 #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  output logic [WIDTH-1:0] o_p
);

  logic signed [3*WIDTH-1:0] w_a, w_b, w_c, w_p;

  assign w_a = {{(2*WIDTH){i_a[WIDTH-1]}}, i_a};
  assign w_b = {{(2*WIDTH){i_b[WIDTH-1]}}, i_b};
  assign w_c = {{(2*WIDTH){i_c[WIDTH-1]}}, i_c};
  assign w_p = w_a * w_b * w_c;
  assign o_p = WIDTH'(w_p >>> (2 * FRAC));

endmodule

// File: rtl/mult3_arbiter_rr.sv
// NREQ-way round-robin arbiter: grants the first requester at or above the
// pointer, wrapping modulo NREQ. Purely combinational; pointer lives outside.
module mult3_arbiter_rr
  import mult3_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  input  logic            i_en,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  // Search from the pointer upward, first requester wins.
  always_comb begin
    logic w_found;
    int   w_j;
    // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= NREQ) w_j = w_j - NREQ;
      if (i_en && !w_found && i_req[IDW'(w_j)]) begin
        o_grant[IDW'(w_j)] = 1'b1;
        o_idx              = IDW'(w_j);
        w_found            = 1'b1;
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/mult3_arbiter.sv
// Round-robin shared 3-input fixed-point multiplier with a two-stage
// pipeline (operands, result) and valid/ready backpressure on the output.
module mult3_arbiter
  import mult3_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*WIDTH-1:0] i_a,
  input  logic [NREQ*WIDTH-1:0] i_b,
  input  logic [NREQ*WIDTH-1:0] i_c,
  output logic [NREQ-1:0]       o_ack,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [IDW-1:0]        o_id,
  output logic [WIDTH-1:0]      o_result,
  output logic                  o_busy
);

  logic [IDW-1:0]   r_ptr;
  logic             r_s1_v;
  logic [IDW-1:0]   r_s1_id;
  logic [WIDTH-1:0] r_s1_a, r_s1_b, r_s1_c;
  logic             r_valid;
  logic [IDW-1:0]   r_id;
  logic [WIDTH-1:0] r_result;

  logic             w_adv;
  logic [NREQ-1:0]  w_grant;
  logic [IDW-1:0]   w_idx;
  logic             w_any;
  logic [IDW-1:0]   w_ptr_nxt;
  logic [WIDTH-1:0] w_prod;

  // Both stages move together whenever the output slot is free or draining.
  assign w_adv = !r_valid | o_ready;

  mult3_arbiter_rr #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .i_en    (w_adv & !rst),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_ptr_nxt = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;

  mult3_arbiter_mult3 #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mult (
    .i_a (r_s1_a),
    .i_b (r_s1_b),
    .i_c (r_s1_c),
    .o_p (w_prod)
  );

  // Control state: pointer, stage valids and the output registers.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_ptr    <= '0;
      r_s1_v   <= 1'b0;
      r_valid  <= 1'b0;
      r_id     <= '0;
      r_result <= '0;
    end else if (w_adv) begin
      r_valid <= r_s1_v;
      if (r_s1_v) begin
        r_result <= w_prod;
        r_id     <= r_s1_id;
      end
      r_s1_v <= w_any;
      if (w_any) r_ptr <= w_ptr_nxt;
    end
  end

  // Stage-1 operand capture from the granted requester.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers carry no reset; they are only observed when r_s1_v is set.
    if (w_any) begin
      r_s1_id <= w_idx;
      r_s1_a  <= i_a[int'(w_idx)*WIDTH +: WIDTH];
      r_s1_b  <= i_b[int'(w_idx)*WIDTH +: WIDTH];
      r_s1_c  <= i_c[int'(w_idx)*WIDTH +: WIDTH];
    end
  end

  assign o_ack    = w_grant;
  assign o_valid  = r_valid;
  assign o_id     = r_id;
  assign o_result = r_result;
  assign o_busy   = r_s1_v | r_valid;

endmodule

// File: tb/tb_mult3_arbiter.sv
// Self-checking bench for mult3_arbiter: directed scenarios plus a
// randomized run against a cycle-level reference model.
module tb_mult3_arbiter;
  import mult3_arbiter_pkg::*;

  localparam int WIDTH = 32;
  localparam int FRAC  = 24;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       i_req;
  logic [NREQ*WIDTH-1:0] i_a, i_b, i_c;
  logic [NREQ-1:0]       o_ack;
  logic                  o_valid;
  logic                  o_ready;
  logic [IDW-1:0]        o_id;
  logic [WIDTH-1:0]      o_result;
  logic                  o_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mult3_arbiter #(.WIDTH(WIDTH), .FRAC(FRAC), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_c      (i_c),
    .o_ack    (o_ack),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_id     (o_id),
    .o_result (o_result),
    .o_busy   (o_busy)
  );

  // Reference product: exact a*b as 64 bits, then times c, floor-divide by 2^48, keep 32 bits.
  function automatic logic [31:0] ref_mult(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
    longint              ab;
    logic signed [127:0] p;
    ab = longint'($signed(a)) * longint'($signed(b));
    p  = 128'(ab) * 128'($signed(c));
    return p[79:48];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c);
    i_a[i*WIDTH +: WIDTH] = a;
    i_b[i*WIDTH +: WIDTH] = b;
    i_c[i*WIDTH +: WIDTH] = c;
  endtask

  function automatic logic [31:0] exp_of(input int i);
    return ref_mult(i_a[i*WIDTH +: WIDTH], i_b[i*WIDTH +: WIDTH], i_c[i*WIDTH +: WIDTH]);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- reference model for the random run ----------------
  int               m_ptr;
  bit               m_s1v, m_ov;
  int               m_s1id, m_oid;
  logic [31:0]      m_s1res, m_ores;

  task automatic model_reset();
    m_ptr = 0; m_s1v = 0; m_ov = 0; m_s1id = 0; m_oid = 0; m_s1res = '0; m_ores = '0;
  endtask

  function automatic int model_grant();
    if (m_ov && !o_ready) return -1;
    for (int k = 0; k < NREQ; k++) begin
      if (i_req[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_clock(input int g);
    if (!m_ov || o_ready) begin
      m_ov = m_s1v;
      if (m_s1v) begin
        m_oid  = m_s1id;
        m_ores = m_s1res;
      end
      m_s1v = (g >= 0);
      if (g >= 0) begin
        m_s1id  = g;
        m_s1res = exp_of(g);
        m_ptr   = (g + 1) % NREQ;
      end
    end
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom % 3)
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 32'h03FF_FFFF)) - 32'h0200_0000;
      default: return 32'($urandom_range(0, 6)) << FRAC;
    endcase
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; i_req = '1; o_ready = 1'b1; i_a = '0; i_b = '0; i_c = '0;
    tick(); tick();
    checks++; if (o_ack !== 4'b0000) begin failures++; $display("FAIL reset_ack got=%b exp=0000", o_ack); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    checks++; if (o_result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", o_result); end
    checks++; if (o_id !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", o_id); end
    rst = 1'b0; i_req = '0;
    tick();
  endtask

  task automatic run_single(input string name, input int idx, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] c, input logic [31:0] exp);
    logic [NREQ-1:0] e_ack;
    e_ack = NREQ'(1) << idx;
    i_req = '0; o_ready = 1'b1;
    set_op(idx, a, b, c);
    i_req[idx] = 1'b1;
    #1;
    checks++; if (o_ack !== e_ack) begin failures++; $display("FAIL %s_ack got=%b exp=%b", name, o_ack, e_ack); end
    tick();
    i_req = '0;
    #1;
    checks++; if (o_valid !== 1'b0 || o_busy !== 1'b1) begin failures++; $display("FAIL %s_c1 valid=%b busy=%b exp valid=0 busy=1", name, o_valid, o_busy); end
    tick();
    checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL %s_valid got=%b exp=1", name, o_valid); end
    checks++; if (o_id !== IDW'(idx)) begin failures++; $display("FAIL %s_id got=%0d exp=%0d", name, o_id, idx); end
    checks++; if (o_result !== exp) begin failures++; $display("FAIL %s_result got=%h exp=%h", name, o_result, exp); end
    tick();
    checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin failures++; $display("FAIL %s_idle valid=%b busy=%b exp 0 0", name, o_valid, o_busy); end
  endtask

  task automatic test_single();
    run_single("single",  2, 32'h0200_0000, 32'h0080_0000, 32'h0300_0000, 32'h0300_0000);
    run_single("sign",    1, 32'hFF00_0000, 32'h0200_0000, 32'h0180_0000, 32'hFD00_0000);
    run_single("trunc",   0, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000);
    run_single("negtrunc",3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFF);
    run_single("overflow",2, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h0000_0000);
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] e_ack;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 32'(i + 1) << FRAC, ONE, 32'h0080_0000);
    i_req = '1; o_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc == 8) i_req = '0;
      #1;
      e_ack = (cyc < 8) ? NREQ'(1) << (cyc % NREQ) : '0;
      checks++; if (o_ack !== e_ack) begin failures++; $display("FAIL rr_ack cyc=%0d got=%b exp=%b", cyc, o_ack, e_ack); end
      if (cyc >= 2) begin
        checks++;
        if (o_valid !== 1'b1 || o_id !== IDW'((cyc - 2) % NREQ) || o_result !== exp_of((cyc - 2) % NREQ)) begin
          failures++;
          $display("FAIL rr_out cyc=%0d got v=%b id=%0d r=%h exp v=1 id=%0d r=%h", cyc, o_valid, o_id,
                   o_result, (cyc - 2) % NREQ, exp_of((cyc - 2) % NREQ));
        end
      end
      tick();
    end
  endtask

  task automatic test_back_pressure();
    int acks;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 32'(i + 2) << FRAC, 32'hFF80_0000, ONE);
    i_req = '1; o_ready = 1'b0; acks = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      #1;
      if (o_ack != '0) acks++;
      if (cyc == 0) begin
        checks++; if (o_ack !== 4'b0001) begin failures++; $display("FAIL bp_ack0 got=%b exp=0001", o_ack); end
      end else if (cyc == 1) begin
        checks++; if (o_ack !== 4'b0010) begin failures++; $display("FAIL bp_ack1 got=%b exp=0010", o_ack); end
      end else begin
        checks++;
        if (o_ack !== 4'b0000 || o_valid !== 1'b1 || o_id !== 2'd0 || o_result !== exp_of(0)) begin
          failures++;
          $display("FAIL bp_hold cyc=%0d ack=%b v=%b id=%0d r=%h exp ack=0000 v=1 id=0 r=%h", cyc, o_ack,
                   o_valid, o_id, o_result, exp_of(0));
        end
      end
      tick();
    end
    checks++; if (acks !== 2) begin failures++; $display("FAIL bp_ack_count got=%0d exp=2", acks); end
    o_ready = 1'b1; i_req = '0;
    #1;
    checks++; if (o_valid !== 1'b1 || o_id !== 2'd0) begin failures++; $display("FAIL bp_drain0 v=%b id=%0d exp v=1 id=0", o_valid, o_id); end
    tick();
    checks++; if (o_valid !== 1'b1 || o_id !== 2'd1 || o_result !== exp_of(1)) begin failures++; $display("FAIL bp_drain1 v=%b id=%0d r=%h exp v=1 id=1 r=%h", o_valid, o_id, o_result, exp_of(1)); end
    tick();
    checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin failures++; $display("FAIL bp_empty v=%b busy=%b exp 0 0", o_valid, o_busy); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, ONE, ONE, 32'(i + 5) << FRAC);
    i_req = '1; o_ready = 1'b1;
    tick(); tick();
    checks++; if (o_valid !== 1'b1 || o_busy !== 1'b1) begin failures++; $display("FAIL mid_pre v=%b busy=%b exp 1 1", o_valid, o_busy); end
    rst = 1'b1; i_req = 4'b1001;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin failures++; $display("FAIL mid_flush v=%b busy=%b exp 0 0", o_valid, o_busy); end
    checks++; if (o_result !== 32'h0 || o_id !== 2'd0) begin failures++; $display("FAIL mid_regs r=%h id=%0d exp 0 0", o_result, o_id); end
    checks++; if (o_ack !== 4'b0001) begin failures++; $display("FAIL mid_ptr ack=%b exp=0001", o_ack); end
    tick();
    i_req = '0;
    #1;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL mid_c1 v=%b exp=0", o_valid); end
    tick();
    checks++; if (o_valid !== 1'b1 || o_id !== 2'd0 || o_result !== exp_of(0)) begin failures++; $display("FAIL mid_out v=%b id=%0d r=%h exp v=1 id=0 r=%h", o_valid, o_id, o_result, exp_of(0)); end
    tick();
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL mid_tail busy=%b exp=0", o_busy); end
  endtask

  task automatic test_random();
    int              g;
    logic [NREQ-1:0] e_ack;
    int              waits [NREQ];
    bit              last  [NREQ];
    do_reset();
    model_reset();
    i_req = '0;
    for (int i = 0; i < NREQ; i++) begin waits[i] = 0; last[i] = 0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (last[i]) begin
          if ($urandom % 10 < 7) set_op(i, rand_op(), rand_op(), rand_op());
          else i_req[i] = 1'b0;
        end else if (!i_req[i] && ($urandom % 10 < 4)) begin
          set_op(i, rand_op(), rand_op(), rand_op());
          i_req[i] = 1'b1;
        end
      end
      o_ready = ($urandom % 4) != 0;
      @(negedge clk);
      g     = model_grant();
      e_ack = (g >= 0) ? NREQ'(1) << g : '0;
      checks++; if (o_ack !== e_ack) begin failures++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", cyc, o_ack, e_ack); end
      checks++; if (o_valid !== m_ov) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, o_valid, m_ov); end
      if (m_ov) begin
        checks++;
        if (o_id !== IDW'(m_oid) || o_result !== m_ores) begin
          failures++;
          $display("FAIL rnd_out cyc=%0d got id=%0d r=%h exp id=%0d r=%h", cyc, o_id, o_result, m_oid, m_ores);
        end
      end
      checks++; if (o_busy !== (m_s1v | m_ov)) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, o_busy, m_s1v | m_ov); end
      for (int i = 0; i < NREQ; i++) if (!i_req[i]) waits[i] = 0;
      if (g >= 0) begin
        checks++; if (waits[g] > NREQ - 1) begin failures++; $display("FAIL rnd_fair cyc=%0d id=%0d waited=%0d max=%0d", cyc, g, waits[g], NREQ - 1); end
        for (int i = 0; i < NREQ; i++) if (i != g && i_req[i]) waits[i]++;
        waits[g] = 0;
      end
      for (int i = 0; i < NREQ; i++) last[i] = (g == i);
      model_clock(g);
      tick();
    end
    i_req = '0; o_ready = 1'b1;
    tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
